// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for wb_port_arbiter
// Contents: arbitration state enum, one-hot grant encodings, timeout counter width,
//           and a helper that maps a state to its grant vector.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

  localparam int TMO_CNT_W = 16;

  function automatic logic [1:0] grant_of(input arb_state_e s);
    case (s)
      OWN_A:   grant_of = GRANT_A;
      OWN_B:   grant_of = GRANT_B;
      default: grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// rtl/wb_arb_timeout.sv - stall counter that flags a bus timeout
// Ports: clk, rst_n (async active-low), stall (owner waiting on ack this cycle),
//        clear (ack seen or ownership changing), expired (count reached TIMEOUT_CYCLES).
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic clear,
  output logic expired
);

  localparam logic [TMO_CNT_W-1:0] LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

  logic [TMO_CNT_W-1:0] count;

  // The expiry cycle itself restarts the count so a still-stalled owner
  // gets a fresh full window before the next error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (stall) begin
      count <= count + TMO_CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-master Wishbone arbiter in front of wb_openram_wrapper
// Ports: wb_clk_i / wb_rst_n_i (async assert, synchronised release);
//        wbs_a_* port A (management) and wbs_b_* port B (user) slave interfaces;
//        wbm_* single master interface to the RAM wrapper; grant_o one-hot {B,A}.
// Optional: define WB_ARB_TIMEOUT_EN to enable the stall timeout (err pulse to owner).
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_a_cyc_i,
  input  logic        wbs_a_stb_i,
  input  logic        wbs_a_we_i,
  input  logic [3:0]  wbs_a_sel_i,
  input  logic [31:0] wbs_a_adr_i,
  input  logic [31:0] wbs_a_dat_i,
  output logic        wbs_a_ack_o,
  output logic        wbs_a_err_o,
  output logic [31:0] wbs_a_dat_o,
  input  logic        wbs_b_cyc_i,
  input  logic        wbs_b_stb_i,
  input  logic        wbs_b_we_i,
  input  logic [3:0]  wbs_b_sel_i,
  input  logic [31:0] wbs_b_adr_i,
  input  logic [31:0] wbs_b_dat_i,
  output logic        wbs_b_ack_o,
  output logic        wbs_b_err_o,
  output logic [31:0] wbs_b_dat_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [1:0]  grant_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  // Release-side synchroniser: this flop plus the state register form the
  // two stages, so the first grant can land on the 2nd edge after release.
  logic rst_meta;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_meta <= 1'b0;
    else             rst_meta <= 1'b1;
  end

  arb_state_e state, state_next;
  logic       last_owner, last_owner_next;  // 1 = port B had the bus last
  logic       req_a, req_b, own_a, own_b, tmo;

  assign req_a = wbs_a_cyc_i & wbs_a_stb_i;
  assign req_b = wbs_b_cyc_i & wbs_b_stb_i;
  assign own_a = (state == OWN_A);
  assign own_b = (state == OWN_B);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    case (state)
      IDLE: begin
        if (rst_meta) begin
          if (req_a && req_b) state_next = last_owner ? OWN_A : OWN_B;
          else if (req_a)     state_next = OWN_A;
          else if (req_b)     state_next = OWN_B;
        end
      end
      OWN_A: begin
        if (!wbs_a_cyc_i) begin
          state_next      = IDLE;
          last_owner_next = 1'b0;
        end
      end
      OWN_B: begin
        if (!wbs_b_cyc_i) begin
          state_next      = IDLE;
          last_owner_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request path is a pure mux of the owner's inputs; stb is qualified by
  // cyc so a master abandoning a cycle also drops the strobe immediately.
  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = '0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    if (own_a) begin
      wbm_cyc_o = wbs_a_cyc_i & ~tmo;
      wbm_stb_o = wbs_a_cyc_i & wbs_a_stb_i & ~tmo;
      wbm_we_o  = wbs_a_we_i;
      wbm_sel_o = wbs_a_sel_i;
      wbm_adr_o = wbs_a_adr_i;
      wbm_dat_o = wbs_a_dat_i;
    end else if (own_b) begin
      wbm_cyc_o = wbs_b_cyc_i & ~tmo;
      wbm_stb_o = wbs_b_cyc_i & wbs_b_stb_i & ~tmo;
      wbm_we_o  = wbs_b_we_i;
      wbm_sel_o = wbs_b_sel_i;
      wbm_adr_o = wbs_b_adr_i;
      wbm_dat_o = wbs_b_dat_i;
    end
  end

  // Gating ack with wbm_cyc_o discards a slave ack that arrives after the
  // owner has abandoned the cycle (or during a forced timeout cycle).
  assign wbs_a_ack_o = own_a & wbm_cyc_o & wbm_ack_i;
  assign wbs_b_ack_o = own_b & wbm_cyc_o & wbm_ack_i;
  assign wbs_a_dat_o = own_a ? wbm_dat_i : '0;
  assign wbs_b_dat_o = own_b ? wbm_dat_i : '0;
  assign wbs_a_err_o = own_a & tmo;
  assign wbs_b_err_o = own_b & tmo;
  assign grant_o     = grant_of(state);

`ifdef WB_ARB_TIMEOUT_EN
  logic tmo_stall, tmo_clear;

  assign tmo_stall = (state != IDLE) & wbm_stb_o & ~wbm_ack_i;
  assign tmo_clear = ((state != IDLE) & wbm_ack_i) | (state_next != state);

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .stall   (tmo_stall),
    .clear   (tmo_clear),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

endmodule
